alu_ctrl_fsm: RTL and testbench
===============================

Name: alu_ctrl_fsm

Overview:
- Multi-cycle controller FSM for the 8-bit accumulator processor.
- Fetches an 8-bit instruction (opcode [7:4], operand [3:0]) and sequences the combinational 8-bit ALU, accumulator (ACC) and register file.
- Drives alu_select, ACC and register load strobes, the ACC source mux and the PC.
- Registers the ALU zero and carry flags for conditional jumps.

Parameters:
- PC_W, 4: program counter width. Jump targets are the operand zero-extended to PC_W.
- ALU_WAIT_CYC, 1: settle cycles (>=1) between presenting alu_select and capturing the ALU result. Covers the ALU's 5 ns modelled delay.

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  level; leaves IDLE and begins fetching at pc
- instr  in  8  instruction memory read data at address pc
- alu_zero_flag  in  1  ALU zero result
- alu_carry_out  in  1  ALU carry/borrow
- pc  out  PC_W  instruction address
- ir_load  out  1  one-cycle strobe to capture instr
- alu_select  out  4  ALU opcode; NOP (4'b0000) outside the ALU window
- acc_load  out  1  one-cycle ACC write strobe
- acc_src_sel  out  2  ACC mux: 0 = ALU, 1 = register, 2 = immediate
- reg_load  out  1  one-cycle register write strobe (data = ACC)
- reg_addr  out  4  register index, equal to IR[3:0]
- imm  out  8  {4'b0, IR[3:0]}
- zero_flag  out  1  registered Z
- carry_flag  out  1  registered C
- busy  out  1  high in every state except IDLE and HALT
- halted  out  1  high in HALT

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, pc=0, IR=0, zero_flag=0, carry_flag=0, alu_select=NOP.
  - All strobes 0, acc_src_sel=0, busy=0, halted=0.
  - Asserting reset mid-instruction aborts it; no strobe is emitted.
- Opcodes:
  - ALU ops (fixed values): NOP 0000, ADD 0001, SUB 0010, NOR 0011, SHFR 1011, SHFL 1100.
  - Controller ops: LDR 0101 (ACC<=reg), STR 0110 (reg<=ACC), LDI 0111 (ACC<=imm), JMP 1000, JZ 1001, JC 1010, HLT 1111.
  - Undefined opcodes 0100, 1101, 1110 execute as NOP.
- States: IDLE, FETCH, DECODE, EXEC, ALU_WAIT, WB, HALT.
- IDLE: outputs idle; go to FETCH when start=1.
- FETCH: ir_load=1; IR<=instr at the clock edge; next state DECODE.
- DECODE: classify IR; next state EXEC.
- EXEC for NOP, LDR, STR, LDI and undefined opcodes:
  - Pulse the matching strobe: LDR gives acc_load with acc_src_sel=1; STR gives reg_load; LDI gives acc_load with acc_src_sel=2.
  - pc<=pc+1; next state FETCH.
- EXEC for jumps:
  - JMP always taken.
  - JZ taken iff zero_flag=1; JC taken iff carry_flag=1.
  - Taken: pc<=operand. Not taken: pc<=pc+1. Next state FETCH.
- EXEC for HLT: pc unchanged; next state HALT.
- EXEC for ALU ops (ADD/SUB/NOR/SHFL/SHFR):
  - alu_select<=IR[7:4], held stable through ALU_WAIT and WB.
  - Load a wait counter with ALU_WAIT_CYC-1; next state ALU_WAIT.
- ALU_WAIT: decrement the counter each cycle; go to WB when it reaches 0.
- WB:
  - acc_load=1, acc_src_sel=0.
  - zero_flag<=alu_zero_flag, carry_flag<=alu_carry_out.
  - pc<=pc+1; next state FETCH; alu_select returns to NOP.
- Flag rules: flags change only in WB of ALU ops. NOP, loads, stores and jumps preserve them.
- Latency:
  - ALU op: 4+ALU_WAIT_CYC cycles.
  - Other ops: 3 cycles.
- pc wraps from 2^PC_W-1 to 0 with no side effect.
- HALT: halted=1; leave only through reset. start is ignored.
- start is ignored while busy=1.
- acc_load and reg_load are never high in the same cycle.

Optional Feature:
- Macro: SINGLE_STEP_EN.
- Defined:
  - Adds input port step (1 bit) and state PAUSE.
  - Every instruction completion (EXEC for non-ALU ops, WB for ALU ops) goes to PAUSE instead of FETCH.
  - PAUSE has busy=1 and moves to FETCH on step=1. Reset returns to IDLE.
- Undefined: no step port, no PAUSE state; the controller runs freely.

Decomposition:
- Shared package alu_pkg:
  - 4-bit opcode constants, the same values the ALU uses.
  - State enum.
  - ACC mux select constants ACC_SRC_ALU/REG/IMM.
  - An is_alu_op classification function.
- One natural sub-module: alu_ctrl_decode. Combinational; maps IR[7:4] to op class (alu/load/store/jump/halt/nop) and jump condition.

Test Plan:
- Reset → idle: assert rst_n=0 mid-ALU_WAIT → pc=0, all strobes 0, flags 0, state IDLE on the same edge.
- Load and add: LDI 5; STR r1; LDI 3; ADD r1 with ALU model 8 + ALU_WAIT_CYC=2 → acc_load in WB of cycle 6 of ADD, ACC=8, Z=0, C=0, pc=4.
- SUB to zero: ACC=5, SUB r1 with r1=5 → Z=1, C=0; then JZ 0xA → pc=0xA. Repeat with Z=0 → pc increments.
- Carry and jump: ACC=0xFF, ADD r with r=1 → ACC=0, Z=0 (9-bit check), C=1; JC 2 → pc=2.
- Flags preserved: after a flag-setting op, run NOP, LDR, STR, LDI, undefined opcode 1101 → flags unchanged, each op 3 cycles.
- Edge cases: pc=0xF with NOP → pc=0; HLT → halted=1, start ignored; with SINGLE_STEP_EN, no FETCH occurs until a step pulse.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, states, ACC mux selects and op classification for the accumulator controller (SINGLE_STEP_EN adds PAUSE)
package alu_pkg;

    // ALU opcodes; these values are shared with the combinational ALU
    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_NOR  = 4'b0011;
    localparam logic [3:0] OP_SHFR = 4'b1011;
    localparam logic [3:0] OP_SHFL = 4'b1100;

    // Controller-only opcodes
    localparam logic [3:0] OP_LDR  = 4'b0101;
    localparam logic [3:0] OP_STR  = 4'b0110;
    localparam logic [3:0] OP_LDI  = 4'b0111;
    localparam logic [3:0] OP_JMP  = 4'b1000;
    localparam logic [3:0] OP_JZ   = 4'b1001;
    localparam logic [3:0] OP_JC   = 4'b1010;
    localparam logic [3:0] OP_HLT  = 4'b1111;

    // ACC input mux selects
    localparam logic [1:0] ACC_SRC_ALU = 2'd0;
    localparam logic [1:0] ACC_SRC_REG = 2'd1;
    localparam logic [1:0] ACC_SRC_IMM = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_ALU_WAIT,
        S_WB,
        S_HALT
`ifdef SINGLE_STEP_EN
        , S_PAUSE
`endif
    } state_e;

    typedef enum logic [2:0] {
        CLS_NOP,
        CLS_ALU,
        CLS_LOAD_REG,
        CLS_LOAD_IMM,
        CLS_STORE,
        CLS_JUMP,
        CLS_HALT
    } op_class_e;

    typedef enum logic [1:0] {
        JCOND_ALWAYS,
        JCOND_ZERO,
        JCOND_CARRY
    } jmp_cond_e;

    function automatic logic is_alu_op(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_NOR) ||
               (op == OP_SHFR) || (op == OP_SHFL);
    endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// rtl/alu_ctrl_decode.sv - combinational opcode classifier: op class and jump condition
module alu_ctrl_decode
    import alu_pkg::*;
(
    input  logic [3:0] opcode,
    output op_class_e  op_class,
    output jmp_cond_e  jmp_cond
);

    // Undefined opcodes fall through to CLS_NOP so they behave as NOP
    always_comb begin
        op_class = CLS_NOP;
        jmp_cond = JCOND_ALWAYS;
        if (is_alu_op(opcode)) begin
            op_class = CLS_ALU;
        end else begin
            case (opcode)
                OP_LDR:  op_class = CLS_LOAD_REG;
                OP_LDI:  op_class = CLS_LOAD_IMM;
                OP_STR:  op_class = CLS_STORE;
                OP_HLT:  op_class = CLS_HALT;
                OP_JMP: begin
                    op_class = CLS_JUMP;
                    jmp_cond = JCOND_ALWAYS;
                end
                OP_JZ: begin
                    op_class = CLS_JUMP;
                    jmp_cond = JCOND_ZERO;
                end
                OP_JC: begin
                    op_class = CLS_JUMP;
                    jmp_cond = JCOND_CARRY;
                end
                default: op_class = CLS_NOP;
            endcase
        end
    end

endmodule

// File: rtl/alu_ctrl_fsm.sv
// rtl/alu_ctrl_fsm.sv - multi-cycle controller for the 8-bit accumulator processor (SINGLE_STEP_EN adds step input and PAUSE state)
module alu_ctrl_fsm
    import alu_pkg::*;
#(
    parameter int PC_W         = 4,
    parameter int ALU_WAIT_CYC = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
`ifdef SINGLE_STEP_EN
    input  logic            step,
`endif
    input  logic [7:0]      instr,
    input  logic            alu_zero_flag,
    input  logic            alu_carry_out,
    output logic [PC_W-1:0] pc,
    output logic            ir_load,
    output logic [3:0]      alu_select,
    output logic            acc_load,
    output logic [1:0]      acc_src_sel,
    output logic            reg_load,
    output logic [3:0]      reg_addr,
    output logic [7:0]      imm,
    output logic            zero_flag,
    output logic            carry_flag,
    output logic            busy,
    output logic            halted
);

    localparam int CNT_W = (ALU_WAIT_CYC > 1) ? $clog2(ALU_WAIT_CYC) : 1;

`ifdef SINGLE_STEP_EN
    localparam state_e DONE_STATE = S_PAUSE;
`else
    localparam state_e DONE_STATE = S_FETCH;
`endif

    state_e            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [7:0]        ir_q, ir_d;
    logic              zero_q, zero_d;
    logic              carry_q, carry_d;
    logic [3:0]        sel_q, sel_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    op_class_e         op_class;
    jmp_cond_e         jmp_cond;
    logic              jmp_taken;
    logic [PC_W-1:0]   pc_inc;
    logic [PC_W-1:0]   jmp_target;

    alu_ctrl_decode u_decode (
        .opcode   (ir_q[7:4]),
        .op_class (op_class),
        .jmp_cond (jmp_cond)
    );

    assign pc_inc     = pc_q + PC_W'(1);
    assign jmp_target = PC_W'(ir_q[3:0]);

    // Jump condition evaluated against the registered flags
    always_comb begin
        jmp_taken = 1'b0;
        case (jmp_cond)
            JCOND_ALWAYS: jmp_taken = 1'b1;
            JCOND_ZERO:   jmp_taken = zero_q;
            JCOND_CARRY:  jmp_taken = carry_q;
            default:      jmp_taken = 1'b0;
        endcase
    end

    // State and datapath-control registers; reset mid-instruction aborts it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
            sel_q   <= OP_NOP;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            zero_q  <= zero_d;
            carry_q <= carry_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and strobe generation; strobes are single-cycle by construction
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        zero_d      = zero_q;
        carry_d     = carry_q;
        sel_d       = sel_q;
        cnt_d       = cnt_q;
        ir_load     = 1'b0;
        acc_load    = 1'b0;
        acc_src_sel = ACC_SRC_ALU;
        reg_load    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_FETCH;
            end
            S_FETCH: begin
                ir_load = 1'b1;
                ir_d    = instr;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                state_d = S_EXEC;
            end
            S_EXEC: begin
                case (op_class)
                    CLS_ALU: begin
                        sel_d   = ir_q[7:4];
                        cnt_d   = CNT_W'(ALU_WAIT_CYC - 1);
                        state_d = S_ALU_WAIT;
                    end
                    CLS_LOAD_REG: begin
                        acc_load    = 1'b1;
                        acc_src_sel = ACC_SRC_REG;
                        pc_d        = pc_inc;
                        state_d     = DONE_STATE;
                    end
                    CLS_LOAD_IMM: begin
                        acc_load    = 1'b1;
                        acc_src_sel = ACC_SRC_IMM;
                        pc_d        = pc_inc;
                        state_d     = DONE_STATE;
                    end
                    CLS_STORE: begin
                        reg_load = 1'b1;
                        pc_d     = pc_inc;
                        state_d  = DONE_STATE;
                    end
                    CLS_JUMP: begin
                        pc_d    = jmp_taken ? jmp_target : pc_inc;
                        state_d = DONE_STATE;
                    end
                    CLS_HALT: begin
                        state_d = S_HALT;
                    end
                    default: begin
                        pc_d    = pc_inc;
                        state_d = DONE_STATE;
                    end
                endcase
            end
            S_ALU_WAIT: begin
                if (cnt_q == '0) state_d = S_WB;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            S_WB: begin
                acc_load    = 1'b1;
                acc_src_sel = ACC_SRC_ALU;
                zero_d      = alu_zero_flag;
                carry_d     = alu_carry_out;
                sel_d       = OP_NOP;
                pc_d        = pc_inc;
                state_d     = DONE_STATE;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
`ifdef SINGLE_STEP_EN
            S_PAUSE: begin
                if (step) state_d = S_FETCH;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    assign pc         = pc_q;
    assign alu_select = sel_q;
    assign reg_addr   = ir_q[3:0];
    assign imm        = {4'b0000, ir_q[3:0]};
    assign zero_flag  = zero_q;
    assign carry_flag = carry_q;
    assign busy       = (state_q != S_IDLE) && (state_q != S_HALT);
    assign halted     = (state_q == S_HALT);

endmodule

// File: tb/tb_alu_ctrl_fsm.sv
// tb/tb_alu_ctrl_fsm.sv - directed self-checking bench for alu_ctrl_fsm with a behavioural ALU/ACC/register file
module tb_alu_ctrl_fsm;

`ifdef SINGLE_STEP_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       step;
    logic [7:0] instr;
    logic       alu_zero_flag;
    logic       alu_carry_out;
    logic [3:0] pc;
    logic       ir_load;
    logic [3:0] alu_select;
    logic       acc_load;
    logic [1:0] acc_src_sel;
    logic       reg_load;
    logic [3:0] reg_addr;
    logic [7:0] imm;
    logic       zero_flag;
    logic       carry_flag;
    logic       busy;
    logic       halted;

    logic [7:0] imem [16];
    logic [7:0] rf   [16] = '{default: 8'h00};
    logic [7:0] acc  = 8'h00;
    logic [8:0] alu_r9;
    logic [7:0] bval;

    int checks = 0;
    int errors = 0;
    int lat;
    int acc_cyc;
    logic [3:0] sel_wb;

    always #5 clk = ~clk;

    alu_ctrl_fsm #(.PC_W(4), .ALU_WAIT_CYC(2)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
`ifdef SINGLE_STEP_EN
        .step          (step),
`endif
        .instr         (instr),
        .alu_zero_flag (alu_zero_flag),
        .alu_carry_out (alu_carry_out),
        .pc            (pc),
        .ir_load       (ir_load),
        .alu_select    (alu_select),
        .acc_load      (acc_load),
        .acc_src_sel   (acc_src_sel),
        .reg_load      (reg_load),
        .reg_addr      (reg_addr),
        .imm           (imm),
        .zero_flag     (zero_flag),
        .carry_flag    (carry_flag),
        .busy          (busy),
        .halted        (halted)
    );

    assign instr = imem[pc];

    // Behavioural ALU: 9-bit result, carry/borrow in bit 8, zero over all 9 bits
    always_comb begin
        bval = rf[reg_addr];
        case (alu_select)
            4'b0001: alu_r9 = {1'b0, acc} + {1'b0, bval};
            4'b0010: alu_r9 = {1'b0, acc} - {1'b0, bval};
            4'b0011: alu_r9 = {1'b0, ~(acc | bval)};
            4'b1011: alu_r9 = {acc[0], 1'b0, acc[7:1]};
            4'b1100: alu_r9 = {acc, 1'b0};
            default: alu_r9 = 9'h000;
        endcase
        alu_zero_flag = (alu_r9 == 9'h000);
        alu_carry_out = alu_r9[8];
    end

    // ACC and register file driven by the controller strobes
    always @(posedge clk) begin
        if (acc_load) begin
            case (acc_src_sel)
                2'd1:    acc <= rf[reg_addr];
                2'd2:    acc <= imm;
                default: acc <= alu_r9[7:0];
            endcase
        end
        if (reg_load) rf[reg_addr] <= acc;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && acc_load === 1'b1) chk("strobe_excl", {31'b0, reg_load}, 32'd0);
    end

    // Called at the FETCH negedge of an instruction; returns at the next FETCH negedge
    task automatic next_instr();
        lat     = 0;
        acc_cyc = 0;
        sel_wb  = 4'hx;
        do begin
            @(negedge clk);
            lat++;
            if (acc_load) begin
                acc_cyc = lat + 1;
                sel_wb  = alu_select;
            end
        end while (!ir_load && lat < 40);
    endtask

    initial begin
        step  = 1'b1;
        rst_n = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 16; i++) imem[i] = 8'h00;
        imem[0]  = 8'h75; // LDI 5
        imem[1]  = 8'h61; // STR r1
        imem[2]  = 8'h73; // LDI 3
        imem[3]  = 8'h11; // ADD r1
        imem[4]  = 8'h75; // LDI 5
        imem[5]  = 8'h21; // SUB r1
        imem[6]  = 8'h9A; // JZ 0xA
        imem[10] = 8'h00; // NOP
        imem[11] = 8'h51; // LDR r1
        imem[12] = 8'h62; // STR r2
        imem[13] = 8'h7F; // LDI 0xF
        imem[14] = 8'hD0; // undefined
        imem[15] = 8'h00; // NOP, wraps pc

        repeat (2) @(negedge clk);
        chk("rst_pc", pc, 0);
        chk("rst_busy", busy, 0);
        chk("rst_halted", halted, 0);
        chk("rst_strobes", {ir_load, acc_load, reg_load}, 0);
        chk("rst_sel", alu_select, 0);
        chk("rst_src", acc_src_sel, 0);
        chk("rst_flags", {zero_flag, carry_flag}, 0);

        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_busy", busy, 0);
        start = 1'b1;
        @(negedge clk);
        chk("fetch0_irload", ir_load, 1);
        chk("fetch0_busy", busy, 1);
        start = 1'b0;

        next_instr(); chk("ldi5_lat", lat, 3 + P); chk("ldi5_acc", acc, 8'h05);
        next_instr(); chk("str1_r1", rf[1], 8'h05); chk("str1_pc", pc, 2);
        next_instr(); chk("ldi3_acc", acc, 8'h03);
        next_instr();
        chk("add_lat", lat, 6 + P);
        chk("add_acc_cyc", acc_cyc, 6);
        chk("add_sel_wb", sel_wb, 4'h1);
        chk("add_acc", acc, 8'h08);
        chk("add_flags", {zero_flag, carry_flag}, 2'b00);
        chk("add_pc", pc, 4);
        chk("add_sel_nop", alu_select, 0);
        next_instr();
        next_instr(); chk("sub_acc", acc, 8'h00); chk("sub_flags", {zero_flag, carry_flag}, 2'b10);
        next_instr(); chk("jz_taken_pc", pc, 4'hA); chk("jz_lat", lat, 3 + P);

        imem[0] = 8'h71; // LDI 1
        imem[1] = 8'h63; // STR r3
        imem[2] = 8'h70; // LDI 0
        imem[3] = 8'h30; // NOR r0
        imem[4] = 8'h99; // JZ 9 (not taken)
        imem[5] = 8'h13; // ADD r3
        imem[6] = 8'hA2; // JC 2

        next_instr(); chk("nop_flags", {zero_flag, carry_flag}, 2'b10); chk("nop_lat", lat, 3 + P);
        next_instr(); chk("ldr_acc", acc, 8'h05); chk("ldr_flags", {zero_flag, carry_flag}, 2'b10);
        next_instr(); chk("str2_r2", rf[2], 8'h05); chk("str_flags", {zero_flag, carry_flag}, 2'b10);
        next_instr(); chk("ldif_acc", acc, 8'h0F); chk("ldi_flags", {zero_flag, carry_flag}, 2'b10);
        next_instr(); chk("undef_pc", pc, 4'hF); chk("undef_lat", lat, 3 + P);
        chk("undef_flags", {zero_flag, carry_flag}, 2'b10); chk("undef_acc", acc, 8'h0F);
        next_instr(); chk("wrap_pc", pc, 0); chk("wrap_lat", lat, 3 + P);

        next_instr(); chk("ldi1_acc", acc, 8'h01);
        next_instr(); chk("str3_r3", rf[3], 8'h01);
        next_instr(); chk("ldi0_acc", acc, 8'h00);
        next_instr(); chk("nor_acc", acc, 8'hFF); chk("nor_flags", {zero_flag, carry_flag}, 2'b00);
        next_instr(); chk("jz_not_taken_pc", pc, 5);
        next_instr(); chk("addc_acc", acc, 8'h00); chk("addc_flags", {zero_flag, carry_flag}, 2'b01);
        imem[2] = 8'h13; // ADD r3, aborted by reset
        next_instr(); chk("jc_taken_pc", pc, 2);

        repeat (3) @(negedge clk);
        chk("wait_sel", alu_select, 4'h1);
        chk("wait_busy", busy, 1);
        chk("wait_acc_load", acc_load, 0);
        rst_n = 1'b0;
        #1;
        chk("abort_pc", pc, 0);
        chk("abort_sel", alu_select, 0);
        chk("abort_busy", busy, 0);
        chk("abort_flags", {zero_flag, carry_flag}, 2'b00);
        chk("abort_strobes", {ir_load, acc_load, reg_load}, 0);

        @(negedge clk);
        rst_n = 1'b1;
        imem[0] = 8'hF0; // HLT
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        chk("hlt_fetch", ir_load, 1);
        repeat (3) @(negedge clk);
        chk("hlt_halted", halted, 1);
        chk("hlt_busy", busy, 0);
        chk("hlt_pc", pc, 0);
        repeat (4) @(negedge clk);
        chk("hlt_start_ignored", {halted, ir_load}, 2'b10);
        chk("hlt_pc_hold", pc, 0);
        start = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
